// File: rtl/alu_mc_if.sv
// Handshake and operand bus between the control unit and the multi-cycle ALU.
// The control unit drives operands and start; the ALU answers with busy/done/result/status.
interface alu_mc_if #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
);
  logic             start;
  logic [WIDTH-1:0] rsa;
  logic [WIDTH-1:0] rsb;
  logic [IMM_W-1:0] imm;
  logic [1:0]       alu_op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       stat;
  logic             stat_en;

  modport master (
    output start, rsa, rsb, imm, alu_op,
    input  busy, done, alu_result, stat, stat_en
  );

  modport slave (
    input  start, rsa, rsb, imm, alu_op,
    output busy, done, alu_result, stat, stat_en
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift, iterative unsigned
// shift-add multiply and restoring divide, with start/busy/done handshake.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
) (
  input  logic    clk,
  input  logic    rst,
  alu_mc_if.slave bus
);
  localparam int LW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, EXEC1, MUL, DIV} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [3:0]         fn_q, fn_d;
  logic [3:0]         stat_q, stat_d;
  logic [1:0]         op_q, op_d;
  logic [LW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               sten_q, sten_d;

  function automatic logic sten_fn(input logic [1:0] op, input logic [3:0] fn);
    return !op[1] && (op[0] || fn == 4'd1 || fn == 4'd2 || fn == 4'd12 || fn == 4'd14);
  endfunction

  // ---------------- single-cycle datapath (operates on the bus directly) ----
  logic [3:0]         funct;
  logic [WIDTH-1:0]   imm_x, add_b, sc_res;
  logic [WIDTH:0]     sum_x, dif_x;
  logic [2*WIDTH-1:0] rot_r, rot_l;
  logic               is_add, sh_big, sc_c, sc_v;
  logic [3:0]         sc_stat;

  always_comb begin
    funct  = bus.imm[3:0];
    imm_x  = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
    is_add = bus.alu_op[0] || funct == 4'd0 || funct == 4'd1 || funct == 4'd3;
    add_b  = bus.alu_op[0] ? imm_x : bus.rsb;
    sum_x  = {1'b0, bus.rsa} + {1'b0, add_b};
    dif_x  = {1'b0, bus.rsa} - {1'b0, bus.rsb};
    rot_r  = {bus.rsa, bus.rsa} >> bus.rsb[LW-1:0];
    rot_l  = {bus.rsa, bus.rsa} << bus.rsb[LW-1:0];
    sh_big = |bus.rsb[M:LW];
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    if (is_add) begin
      sc_res = sum_x[M:0];
      sc_c   = sum_x[WIDTH];
      sc_v   = (bus.rsa[M] == add_b[M]) && (sum_x[M] != bus.rsa[M]);
    end else begin
      unique case (funct)
        4'd2: begin
          sc_res = dif_x[M:0];
          sc_c   = dif_x[WIDTH];
          sc_v   = (bus.rsa[M] != bus.rsb[M]) && (dif_x[M] != bus.rsa[M]);
        end
        4'd4:    sc_res = ~bus.rsa;
        4'd5:    sc_res = bus.rsa | bus.rsb;
        4'd6:    sc_res = bus.rsa & bus.rsb;
        4'd7:    sc_res = bus.rsa ^ bus.rsb;
        4'd8:    sc_res = rot_r[M:0];
        4'd9:    sc_res = rot_l[2*WIDTH-1:WIDTH];
        4'd10:   sc_res = sh_big ? '0 : bus.rsa >> bus.rsb[LW-1:0];
        4'd11:   sc_res = sh_big ? '0 : bus.rsa << bus.rsb[LW-1:0];
        default: sc_res = '0;
      endcase
    end
    // N is the sign of the ideal result, so overflow flips the raw MSB
    sc_stat = {sc_c, sc_v, sc_res[M] ^ sc_v, sc_res == '0};
  end

  // ---------------- iteration step for multiply and divide ------------------
  logic [WIDTH:0]     mul_sum, div_trial, div_diff;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt;

  always_comb begin
    // acc = {partial product high, multiplier shifting out at the bottom}
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_nxt   = {mul_sum, acc_q[M:1]};
    // acc = {remainder, dividend shifting out at the top / quotient in at the bottom}
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[M]};
    div_diff  = div_trial - {1'b0, b_q};
    div_nxt   = {div_diff[WIDTH] ? div_trial[M:0] : div_diff[M:0], acc_q[M-1:0], ~div_diff[WIDTH]};
  end

  // ---------------- control ----------------
  logic [WIDTH-1:0] mc_res;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    fn_d    = fn_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    stat_d  = stat_q;
    done_d  = 1'b0;
    sten_d  = 1'b0;
    mc_res  = '0;
    unique case (state_q)
      // EXEC1 is the done cycle of a single-cycle op and is as free as IDLE
      IDLE, EXEC1: begin
        state_d = IDLE;
        if (bus.start) begin
          fn_d  = funct;
          op_d  = bus.alu_op;
          b_d   = bus.rsb;
          acc_d = {{WIDTH{1'b0}}, bus.rsa};
          cnt_d = '0;
          if (bus.alu_op[0] || funct < 4'd12) begin
            state_d = EXEC1;
            res_d   = sc_res;
            stat_d  = sc_stat;
            done_d  = 1'b1;
            sten_d  = sten_fn(bus.alu_op, funct);
          end else begin
            state_d = funct[1] ? DIV : MUL;
          end
        end
      end
      MUL: begin
        acc_d = mul_nxt;
        cnt_d = cnt_q + LW'(1);
        if (cnt_q == LW'(WIDTH-1)) begin
          mc_res  = fn_q[0] ? mul_nxt[2*WIDTH-1:WIDTH] : mul_nxt[M:0];
          state_d = IDLE;
          res_d   = mc_res;
          stat_d  = {1'b0, |mul_nxt[2*WIDTH-1:WIDTH], mc_res[M], mc_res == '0};
          done_d  = 1'b1;
          sten_d  = sten_fn(op_q, fn_q);
        end
      end
      DIV: begin
        acc_d = div_nxt;
        cnt_d = cnt_q + LW'(1);
        if (cnt_q == LW'(WIDTH-1)) begin
          // a zero divisor naturally yields all-ones quotient and remainder = rsa
          mc_res  = fn_q[0] ? div_nxt[2*WIDTH-1:WIDTH] : div_nxt[M:0];
          state_d = IDLE;
          res_d   = mc_res;
          stat_d  = {1'b0, b_q == '0, mc_res[M], mc_res == '0};
          done_d  = 1'b1;
          sten_d  = sten_fn(op_q, fn_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      fn_q    <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      stat_q  <= '0;
      done_q  <= 1'b0;
      sten_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      fn_q    <= fn_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      stat_q  <= stat_d;
      done_q  <= done_d;
      sten_q  <= sten_d;
    end
  end

  assign bus.busy       = (state_q == MUL) || (state_q == DIV);
  assign bus.done       = done_q;
  assign bus.alu_result = res_q;
  assign bus.stat       = stat_q;
  assign bus.stat_en    = sten_q;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: arithmetic reference model checked every cycle, plus
// directed vectors with hand-computed results, latencies and status flags.
module tb_alu_mc;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W), .IMM_W(16)) bus ();
  alu_mc #(.WIDTH(W), .IMM_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: what the result, flags and stat_en must be for one operation.
  function automatic void model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [15:0] im, input logic [1:0] op,
                                   output logic [W-1:0] r, output logic [3:0] st,
                                   output logic en, output bit multi);
    logic [3:0]  f;
    logic [W-1:0] bb, t;
    logic [63:0] p;
    longint      ia, ib, ideal;
    logic        c, v, n;
    bit          arith;
    f = im[3:0]; c = 1'b0; v = 1'b0; multi = 0; arith = 0; ideal = 0; r = '0;
    ia = longint'($signed(a));
    ib = longint'($signed(b));
    if (op[0] || f == 4'd0 || f == 4'd1 || f == 4'd3) begin
      bb = op[0] ? {{16{im[15]}}, im} : b;
      ib = longint'($signed(bb));
      p  = 64'(a) + 64'(bb);
      r  = p[W-1:0];
      c  = p[32];
      ideal = ia + ib; arith = 1;
    end else begin
      case (f)
        4'd2: begin r = a - b; c = a < b; ideal = ia - ib; arith = 1; end
        4'd4: r = ~a;
        4'd5: r = a | b;
        4'd6: r = a & b;
        4'd7: r = a ^ b;
        4'd8: begin t = a; for (int i = 0; i < int'(b[4:0]); i++) t = {t[0], t[W-1:1]}; r = t; end
        4'd9: begin t = a; for (int i = 0; i < int'(b[4:0]); i++) t = {t[W-2:0], t[W-1]}; r = t; end
        4'd10: r = (b >= W) ? '0 : a >> b;
        4'd11: r = (b >= W) ? '0 : a << b;
        4'd12, 4'd13: begin
          p = 64'(a) * 64'(b);
          r = (f == 4'd12) ? p[31:0] : p[63:32];
          v = p[63:32] != 0; multi = 1;
        end
        default: begin
          multi = 1;
          if (b == 0) begin r = (f == 4'd14) ? '1 : a; v = 1'b1; end
          else r = (f == 4'd14) ? a / b : a % b;
        end
      endcase
    end
    if (arith) begin
      v = (ideal > 64'sd2147483647) || (ideal < -64'sd2147483648);
      n = ideal < 0;
    end else n = r[W-1];
    st = {c, v, n, r == '0};
    en = !op[1] && (op[0] || f inside {4'd1, 4'd2, 4'd12, 4'd14});
  endfunction

  // Cycle model: operations occupy WIDTH busy cycles or none, then one done cycle.
  logic [W-1:0] m_res = '0, p_res = '0, t_res;
  logic [3:0]   m_stat = '0, p_stat = '0, t_stat;
  logic         m_done = 0, m_sten = 0, m_busy = 0, p_sten = 0, t_en;
  bit           t_multi, chk_on = 0;
  int           m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_res = '0; m_stat = '0; m_done = 0; m_sten = 0; m_busy = 0; m_left = 0;
      chk_on = 1;
    end else begin
      m_done = 0; m_sten = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_res = p_res; m_stat = p_stat; m_sten = p_sten;
        end
      end else if (bus.start) begin
        model_op(bus.rsa, bus.rsb, bus.imm, bus.alu_op, t_res, t_stat, t_en, t_multi);
        if (t_multi) begin
          m_busy = 1; m_left = W; p_res = t_res; p_stat = t_stat; p_sten = t_en;
        end else begin
          m_done = 1; m_res = t_res; m_stat = t_stat; m_sten = t_en;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_busy",    W'(bus.busy),    W'(m_busy));
      chk("cyc_done",    W'(bus.done),    W'(m_done));
      chk("cyc_stat_en", W'(bus.stat_en), W'(m_sten));
      chk("cyc_result",  bus.alu_result,  m_res);
      chk("cyc_stat",    W'(bus.stat),    W'(m_stat));
    end
  end

  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [15:0] im, input logic [1:0] op);
    bus.rsa = a; bus.rsb = b; bus.imm = im; bus.alu_op = op; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(inout int cyc);
    while (!bus.done && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk("done_seen", W'(bus.done), W'(1));
  endtask

  task automatic op_chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [15:0] im, input logic [1:0] op,
                        input logic [W-1:0] er, input logic [3:0] es,
                        input logic een, input int elat);
    int cyc;
    go(a, b, im, op);
    cyc = 1;
    wait_done(cyc);
    chk({nm, "_res"},  bus.alu_result, er);
    chk({nm, "_stat"}, W'(bus.stat), W'(es));
    chk({nm, "_sten"}, W'(bus.stat_en), W'(een));
    chk({nm, "_lat"},  W'(cyc), W'(elat));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, dcnt;
    bus.start = 0; bus.rsa = '0; bus.rsb = '0; bus.imm = '0; bus.alu_op = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_result", bus.alu_result, '0);
    chk("rst_stat",   W'(bus.stat), '0);
    chk("rst_done",   W'(bus.done), '0);
    chk("rst_busy",   W'(bus.busy), '0);

    // add / sub / immediate
    op_chk("add_ovf", 32'h7FFFFFFF, 32'd1, 16'h0001, 2'b00, 32'h80000000, 4'b0100, 1'b1, 1);
    op_chk("sub_brw", 32'd5, 32'd7, 16'h0002, 2'b00, 32'hFFFFFFFE, 4'b1010, 1'b1, 1);
    op_chk("sub_zero", 32'd9, 32'd9, 16'h0002, 2'b00, 32'h0, 4'b0001, 1'b1, 1);
    op_chk("addi", 32'h10, 32'd0, 16'hFFF0, 2'b01, 32'h0, 4'b1001, 1'b1, 1);
    op_chk("addi_nost", 32'h10, 32'd0, 16'hFFF0, 2'b11, 32'h0, 4'b1001, 1'b0, 1);
    op_chk("addi_f12", 32'd5, 32'd9, 16'h000C, 2'b01, 32'h11, 4'b0000, 1'b1, 1);

    // back-to-back single-cycle logic ops
    go(32'hF0F0F0F0, 32'h0FF00FF0, 16'h0005, 2'b00);
    chk("or_res", bus.alu_result, 32'hFFF0FFF0);
    go(32'hF0F0F0F0, 32'h0FF00FF0, 16'h0006, 2'b00);
    chk("and_res", bus.alu_result, 32'h00F000F0);
    go(32'hF0F0F0F0, 32'h0FF00FF0, 16'h0007, 2'b00);
    chk("xor_res", bus.alu_result, 32'hFF00FF00);
    go(32'h0, 32'h0, 16'h0004, 2'b00);
    chk("not_res", bus.alu_result, 32'hFFFFFFFF);
    chk("not_stat", W'(bus.stat), W'(4'b0010));

    // rotates and shifts
    op_chk("rotl", 32'h80000001, 32'd1, 16'h0009, 2'b00, 32'h00000003, 4'b0000, 1'b0, 1);
    op_chk("rotr", 32'h00000003, 32'h21, 16'h0008, 2'b00, 32'h80000001, 4'b0010, 1'b0, 1);
    op_chk("shl40", 32'h80000001, 32'd40, 16'h000B, 2'b00, 32'h0, 4'b0001, 1'b0, 1);
    op_chk("shr31", 32'h80000000, 32'd31, 16'h000A, 2'b00, 32'h1, 4'b0000, 1'b0, 1);
    op_chk("shr32", 32'h80000000, 32'd32, 16'h000A, 2'b00, 32'h0, 4'b0001, 1'b0, 1);

    // multiply, with a start pulsed mid-operation that must be ignored
    go(32'hFFFFFFFF, 32'd2, 16'h000C, 2'b00);
    cyc = 1;
    chk("mul_busy", W'(bus.busy), W'(1));
    repeat (5) begin @(posedge clk); #1; cyc++; end
    bus.rsa = 32'd1; bus.rsb = 32'd1; bus.imm = 16'h0001; bus.start = 1'b1;
    @(posedge clk); #1; cyc++;
    bus.start = 1'b0;
    wait_done(cyc);
    chk("mul_lo_res", bus.alu_result, 32'hFFFFFFFE);
    chk("mul_lo_stat", W'(bus.stat), W'(4'b0110));
    chk("mul_lo_lat", W'(cyc), W'(33));
    chk("mul_lo_busy", W'(bus.busy), W'(0));
    op_chk("mul_hi", 32'hFFFFFFFF, 32'd2, 16'h000D, 2'b00, 32'h1, 4'b0100, 1'b0, 33);

    // divide
    op_chk("divu", 32'd100, 32'd7, 16'h000E, 2'b00, 32'd14, 4'b0000, 1'b1, 33);
    op_chk("remu", 32'd100, 32'd7, 16'h000F, 2'b00, 32'd2, 4'b0000, 1'b0, 33);
    op_chk("div0", 32'd100, 32'd0, 16'h000E, 2'b00, 32'hFFFFFFFF, 4'b0110, 1'b1, 33);
    op_chk("rem0", 32'd100, 32'd0, 16'h000F, 2'b00, 32'd100, 4'b0100, 1'b0, 33);

    // reset aborts a divide
    go(32'd100, 32'd7, 16'h000E, 2'b00);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_result", bus.alu_result, '0);
    chk("abort_stat", W'(bus.stat), '0);
    chk("abort_busy", W'(bus.busy), '0);
    dcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.done) dcnt++; end
    chk("abort_nodone", W'(dcnt), W'(0));

    // reset and start together: reset wins
    bus.rsa = 32'd3; bus.rsb = 32'd4; bus.imm = 16'h0001; bus.alu_op = 2'b00;
    bus.start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; rst = 1'b0;
    chk("rst_start_done", W'(bus.done), W'(0));
    chk("rst_start_res", bus.alu_result, '0);
    op_chk("after_rst", 32'd3, 32'd4, 16'h0001, 2'b00, 32'd7, 4'b0000, 1'b1, 1);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, width-parametrised successor to the SISC single-cycle ALU. It keeps the existing function codes and status semantics (C, V, N, Z), adds iterative unsigned multiply and divide on the four spare codes, and uses a start/busy/done handshake so the control unit can stall on long operations. It sits between the register file read ports and the writeback mux, and feeds the status register.

## Interface
- WIDTH, 32: datapath width; must be a power of two, 8 or more.
- IMM_W, 16: immediate width; sign-extended to WIDTH.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin an operation; sampled only in IDLE.
- rsa  in  WIDTH  operand A (Rs).
- rsb  in  WIDTH  operand B (Rt).
- imm  in  IMM_W  immediate; funct = imm[3:0].
- alu_op  in  2  bit0 selects add with sign-extended imm, overriding funct; bit1 suppresses stat_en.
- busy  out  1  high while a multi-cycle operation is in progress.
- done  out  1  one-cycle pulse; alu_result and stat are valid from this cycle.
- alu_result  out  WIDTH  registered result; held until the next done.
- stat  out  4  registered {C, V, N, Z}; held until the next done.
- stat_en  out  1  pulses with done when the status register must load stat.

## Operation
- On start in IDLE, latch rsa, rsb, imm and alu_op into internal registers. Later operand changes have no effect.
- Function codes:
  - 0, 1, 3: add. 2: sub (rsa − rsb).
  - 4: not rsa. 5: or. 6: and. 7: xor.
  - 8: rotate right. 9: rotate left. 10: shift right (logical). 11: shift left.
  - 12: mul low (low WIDTH bits of rsa × rsb). 13: mul high (high WIDTH bits).
  - 14: divu quotient. 15: remu remainder.
- alu_op[0]=1 forces rsa + sext(imm), whatever funct is.
- Rotates use rsb[log2(WIDTH)−1:0]. Shifts use the full rsb value; any amount ≥ WIDTH gives 0.
- Multiply: unsigned shift-add over a 2·WIDTH accumulator, one bit per cycle.
- Divide: unsigned restoring division, one quotient bit per cycle.
- Divide by zero: quotient = all ones, remainder = rsa, V = 1.
- Status for add/sub:
  - C = carry-out (add) or borrow, i.e. rsa < rsb unsigned (sub).
  - V = signed overflow.
  - N = result MSB xor V, the sign of the ideal result.
  - Z = result == 0.
- Status for mul: C = 0, V = (high product half != 0), N = result MSB, Z = result == 0.
- Status for div: C = 0, V = divide-by-zero, N = result MSB, Z = result == 0.
- Status for logic, shift and rotate: C = V = 0, N = result MSB, Z = result == 0.
- stat_en = done and alu_op[1]=0, and either alu_op[0]=1 or funct is one of {1, 2, 12, 14}.
- State machine:
  - IDLE → EXEC1 on start with funct 0–11, or with alu_op[0]=1.
  - IDLE → MUL on start with funct 12 or 13 (and alu_op[0]=0).
  - IDLE → DIV on start with funct 14 or 15 (and alu_op[0]=0).
  - EXEC1 → IDLE after one cycle, pulsing done.
  - MUL and DIV → IDLE after WIDTH iteration cycles, pulsing done on the cycle after the last iteration.

## Timing
- Reset values: busy = 0, done = 0, stat_en = 0, alu_result = 0, stat = 0, state = IDLE, internal counters = 0.
- Single-cycle operations: start at edge N gives done, alu_result and stat at edge N+1. busy stays 0. Back-to-back starts every cycle are allowed.
- Multi-cycle operations: start at edge N gives busy = 1 from N+1 through N+WIDTH, then done at N+WIDTH+1 with busy = 0. Total latency is WIDTH+1 cycles.
- A start is accepted in the done cycle, because the state is already IDLE.
- start while busy is ignored: it is not queued and causes no error.
- rst during MUL or DIV aborts the operation: no done, and all outputs return to reset values on the next edge.
- rst and start in the same cycle: rst wins.
- done and stat_en are never high for more than one consecutive cycle per accepted start.

## Test plan
- Add overflow (WIDTH=32): rsa=0x7FFFFFFF, rsb=1, funct=1, alu_op=00 → next cycle done, alu_result=0x80000000, stat={C0,V1,N0,Z0}, stat_en=1.
- Sub borrow and zero: rsa=5, rsb=7, funct=2 → alu_result=0xFFFFFFFE, stat={1,0,1,0}. Then rsa=rsb=9 → alu_result=0, Z=1.
- Immediate and suppression: rsa=0x10, imm=0xFFF0, alu_op=01 → alu_result=0, stat_en=1. Same stimulus with alu_op=11 → stat_en=0.
- Multiply: rsa=0xFFFFFFFF, rsb=2, funct=12 → busy for 32 cycles, done at cycle 33, alu_result=0xFFFFFFFE, V=1. funct=13 → alu_result=1. A start pulsed mid-operation is ignored.
- Divide: rsa=100, rsb=7, funct=14 → alu_result=14. funct=15 → alu_result=2. rsb=0, funct=14 → alu_result=0xFFFFFFFF, V=1.
- Rotate/shift and reset: rsa=0x80000001, rsb=1, funct=9 → alu_result=0x00000003. rsb=40, funct=11 → alu_result=0. rst asserted during a divide → no done, all outputs 0.
